// File: rtl/vmem_arbiter.sv
// vmem_arbiter: shares the single-ported 8-lane vector data memory between
// the vector core memory stage and the host loader. The core normally wins;
// a host request denied STARVE times in a row is forced through. Read data
// (one-cycle memory latency) is steered back to whoever issued the read.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no host transaction in flight
// ST_HOST | host access issued last cycle, host_ack is due this cycle
module vmem_arbiter #(
  parameter int N      = 20,
  parameter int AW     = 16,
  parameter int STARVE = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [AW-1:0]       core_addr,
  input  logic [7:0][N-1:0]   core_wdata,
  output logic                core_stall,
  output logic                core_rvalid,
  output logic [7:0][N-1:0]   core_rdata,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [AW-1:0]       host_addr,
  input  logic [7:0][N-1:0]   host_wdata,
  output logic                host_ack,
  output logic [7:0][N-1:0]   host_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [7:0][N-1:0]   mem_wdata,
  input  logic [7:0][N-1:0]   mem_rdata
);

  localparam int CW = $clog2(STARVE + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOST = 1'b1
  } st_e;

  st_e           st_q, st_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          crd_q, crd_d;
  logic          hrd_q, hrd_d;

  logic          host_elig;
  logic          starved;
  logic          host_gnt;
  logic          core_gnt;

  // Grant decision; RST gating keeps every output quiet while reset is held.
  always_comb begin
    host_elig = host_req & (st_q != ST_HOST);
    starved   = (wcnt_q == CW'(STARVE));
    host_gnt  = RST & host_elig & (~core_req | starved);
    core_gnt  = RST & core_req & ~host_gnt;
  end

  assign core_stall = RST & core_req & ~core_gnt;

  // Memory port driven from whichever requester holds the grant, else zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (core_gnt) begin
      mem_en    = 1'b1;
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  // Next-state: ack tracking, starvation count (held in the ack cycle), read tags.
  always_comb begin
    st_d   = host_gnt ? ST_HOST : ST_IDLE;
    wcnt_d = wcnt_q;
    if (host_gnt || !host_req) begin
      wcnt_d = '0;
    end else if (host_elig && !starved) begin
      wcnt_d = wcnt_q + CW'(1);
    end
    crd_d = core_gnt & ~core_we;
    hrd_d = host_gnt & ~host_we;
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_q   <= ST_IDLE;
      wcnt_q <= '0;
      crd_q  <= 1'b0;
      hrd_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      wcnt_q <= wcnt_d;
      crd_q  <= crd_d;
      hrd_q  <= hrd_d;
    end
  end

  assign core_rvalid = crd_q;
  assign core_rdata  = crd_q ? mem_rdata : '0;
  assign host_ack    = (st_q == ST_HOST);
  assign host_rdata  = hrd_q ? mem_rdata : '0;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: directed scenarios followed by random traffic,
// checked by a per-cycle scoreboard against a transaction-level model.
module tb_vmem_arbiter;

  localparam int N      = 20;
  localparam int AW     = 16;
  localparam int STARVE = 4;

  typedef logic [7:0][N-1:0] vec_t;

  typedef struct packed {
    logic          stall;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    vec_t          wdata;
    logic          crv;
    vec_t          crd;
    logic          hack;
    vec_t          hrd;
  } exp_t;

  logic          CLK;
  logic          RST;
  logic          core_req, core_we, host_req, host_we;
  logic [AW-1:0] core_addr, host_addr;
  vec_t          core_wdata, host_wdata;
  logic          core_stall, core_rvalid, host_ack;
  vec_t          core_rdata, host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  vec_t          mem_wdata;
  vec_t          mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // reference model state
  vec_t ref_mem [256];
  bit   m_ack_due, m_pc, m_ph;
  int   m_waits;
  vec_t m_pcd, m_phd;

  // random host agent
  bit   h_req, h_we;
  int   h_addr;
  vec_t h_wd;

  vmem_arbiter #(.N(N), .AW(AW), .STARVE(STARVE)) dut (
    .CLK(CLK), .RST(RST),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // memory macro: synchronous, one access per cycle
  vec_t macro_mem [256];
  logic mem_inited = 1'b0;
  always @(posedge CLK) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) macro_mem[i] <= '0;
      mem_inited <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) macro_mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= macro_mem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string nm, input logic [239:0] act, input logic [239:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  function automatic vec_t rvec();
    vec_t v;
    for (int l = 0; l < 8; l++) v[l] = N'($urandom);
    return v;
  endfunction

  // Drive one cycle, predict its outputs from the arbitration rules, queue them.
  task automatic step(input bit rst, input bit rst_mid,
                      input bit creq, input bit cwe, input int caddr, input vec_t cwd,
                      input bit hreq, input bit hwe, input int haddr, input vec_t hwd);
    exp_t e;
    bit   elig, hg, cg;
    @(negedge CLK);
    RST        = rst;
    core_req   = creq;
    core_we    = cwe;
    core_addr  = AW'(caddr);
    core_wdata = cwd;
    host_req   = hreq;
    host_we    = hwe;
    host_addr  = AW'(haddr);
    host_wdata = hwd;
    e    = '0;
    elig = 1'b0;
    hg   = 1'b0;
    cg   = 1'b0;
    if (rst) begin
      e.hack = m_ack_due;
      e.crv  = m_pc;
      e.crd  = m_pc ? m_pcd : '0;
      e.hrd  = m_ph ? m_phd : '0;
      elig   = hreq && !m_ack_due;
      hg     = elig && (!creq || m_waits >= STARVE);
      cg     = creq && !hg;
      e.stall = creq && !cg;
      if (hg) begin
        e.en = 1'b1; e.we = hwe; e.addr = AW'(haddr); e.wdata = hwd;
      end else if (cg) begin
        e.en = 1'b1; e.we = cwe; e.addr = AW'(caddr); e.wdata = cwd;
      end
    end
    exp_q.push_back(e);
    if (!rst || rst_mid) begin
      m_ack_due = 1'b0; m_pc = 1'b0; m_ph = 1'b0; m_waits = 0;
    end else begin
      if (hg) begin
        if (hwe) ref_mem[haddr] = hwd;
        else     m_phd = ref_mem[haddr];
      end
      if (cg) begin
        if (cwe) ref_mem[caddr] = cwd;
        else     m_pcd = ref_mem[caddr];
      end
      if (hg || !hreq)                      m_waits = 0;
      else if (elig && m_waits < STARVE)    m_waits++;
      m_ack_due = hg;
      m_pc      = cg && !cwe;
      m_ph      = hg && !hwe;
    end
    if (rst_mid) begin
      #3;
      RST = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, '0, 0, 0, 0, '0);
  endtask

  // Monitor: compare every DUT output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("core_stall",  240'(core_stall),  240'(e.stall));
        chk("mem_en",      240'(mem_en),      240'(e.en));
        chk("mem_we",      240'(mem_we),      240'(e.we));
        chk("mem_addr",    240'(mem_addr),    240'(e.addr));
        chk("mem_wdata",   240'(mem_wdata),   240'(e.wdata));
        chk("core_rvalid", 240'(core_rvalid), 240'(e.crv));
        chk("core_rdata",  240'(core_rdata),  240'(e.crd));
        chk("host_ack",    240'(host_ack),    240'(e.hack));
        chk("host_rdata",  240'(host_rdata),  240'(e.hrd));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v18, va, c_wd;
    bit   c_req, c_we;
    int   c_addr;
    RST = 1'b0;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    m_ack_due = 0; m_pc = 0; m_ph = 0; m_waits = 0; m_pcd = '0; m_phd = '0;
    h_req = 0; h_we = 0; h_addr = 0; h_wd = '0;
    for (int l = 0; l < 8; l++) v18[l] = N'(l + 1);
    va = '0;
    va[0] = 20'hABCDE;

    // reset held with requests active: everything must read 0
    step(0, 0, 1, 1, 5, rvec(), 1, 0, 6, rvec());
    step(0, 0, 1, 0, 5, rvec(), 1, 1, 6, rvec());
    idle(3);

    // core only: write then read back
    step(1, 0, 1, 1, 16'h10, v18, 0, 0, 0, '0);
    step(1, 0, 1, 0, 16'h10, '0,  0, 0, 0, '0);
    idle(1);

    // host only: write, read presented in ack cycle, granted next, ack
    step(1, 0, 0, 0, 0, '0, 1, 1, 16'h20, va);
    step(1, 0, 0, 0, 0, '0, 1, 0, 16'h20, '0);
    step(1, 0, 0, 0, 0, '0, 1, 0, 16'h20, '0);
    idle(1);

    // starvation: continuous core reads, host read held from cycle 0
    for (int c = 0; c < 5; c++) step(1, 0, 1, 0, 16'h10, '0, 1, 0, 16'h20, '0);
    step(1, 0, 1, 0, 16'h10, '0, 0, 0, 0, '0);
    step(1, 0, 1, 1, 16'h30, rvec(), 0, 0, 0, '0);
    idle(1);

    // simultaneous with low wait count: core wins until it goes quiet
    for (int c = 0; c < 3; c++) step(1, 0, 1, 1, 16'h10 + c, rvec(), 1, 0, 16'h10, '0);
    step(1, 0, 0, 0, 0, '0, 1, 0, 16'h10, '0);
    idle(1);

    // reset between host read grant and its ack edge
    step(1, 1, 0, 0, 0, '0, 1, 0, 16'h20, '0);
    step(0, 0, 1, 0, 16'h20, '0, 1, 0, 16'h20, '0);
    step(1, 0, 1, 0, 16'h20, '0, 1, 0, 16'h10, '0);
    step(1, 0, 0, 0, 0, '0, 1, 0, 16'h10, '0);
    idle(2);

    // random traffic with a host that obeys its hold-until-ack protocol
    for (int i = 0; i < 3000; i++) begin
      if (!h_req || m_ack_due) begin
        h_req  = ($urandom_range(0, 1) == 1);
        h_we   = ($urandom_range(0, 1) == 1);
        h_addr = $urandom_range(0, 15);
        h_wd   = rvec();
      end
      c_req  = ($urandom_range(0, 9) < 7);
      c_we   = ($urandom_range(0, 1) == 1);
      c_addr = $urandom_range(0, 15);
      c_wd   = rvec();
      step(1, 0, c_req, c_we, c_addr, c_wd, h_req, h_we, h_addr, h_wd);
    end
    idle(3);

    @(negedge CLK);
    #4;
    chk("scoreboard_drained", 240'(exp_q.size()), 240'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
